// File: rtl/fetch_group_seq.sv
// Fetch-group sequencer: fetches 8 words, strobes the PC correction unit, delivers a masked group.
// Latency: 8 fetch cycles (zero-wait) + SETTLE_CYCLES + 1 sample cycle before grp_valid rises.
// Backpressure: imem_req holds address until imem_ack; grp_* held stable until grp_ready, fetch paused meanwhile.
module fetch_group_seq #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  InstrF0,
  output logic [31:0]  InstrF1,
  output logic [31:0]  InstrF2,
  output logic [31:0]  InstrF3,
  output logic [31:0]  InstrF4,
  output logic [31:0]  InstrF5,
  output logic [31:0]  InstrF6,
  output logic [31:0]  InstrF7,
  output logic [31:0]  next_PC0,
  output logic [31:0]  next_PC1,
  output logic [31:0]  next_PC2,
  output logic [31:0]  next_PC3,
  output logic [31:0]  next_PC4,
  output logic [31:0]  next_PC5,
  output logic [31:0]  next_PC6,
  output logic [31:0]  next_PC7,
  output logic         new_PC,
  input  logic [31:0]  PC_0,
  input  logic [31:0]  PC_1,
  input  logic [31:0]  PC_2,
  input  logic [31:0]  PC_3,
  input  logic [31:0]  PC_4,
  input  logic [31:0]  PC_5,
  input  logic [31:0]  PC_6,
  input  logic [31:0]  PC_7,
  output logic         grp_valid,
  input  logic         grp_ready,
  output logic [7:0]   grp_mask,
  output logic [255:0] grp_instr,
  output logic [255:0] grp_pc
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_PUBLISH = 2'd1,
    S_SAMPLE  = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  // Last value of the settle counter before leaving PUBLISH.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;

  logic [31:0]   base_q;
  logic [2:0]    k_q;
  logic          req_q;
  logic [3:0]    settle_q;
  logic [31:0]   instr_q [8];
  logic [31:0]   npc_q   [8];
  logic [7:0]    grp_mask_q;
  logic [255:0]  grp_instr_q;
  logic [255:0]  grp_pc_q;

  logic [31:0]   pc_in   [8];
  logic [31:0]   fetch_addr;

  logic          hit;
  logic [2:0]    hit_idx;
  logic [7:0]    mask_d;
  logic [31:0]   nbase_d;

  // Corrected PCs from the correction unit, gathered into an array.
  assign pc_in[0] = PC_0;
  assign pc_in[1] = PC_1;
  assign pc_in[2] = PC_2;
  assign pc_in[3] = PC_3;
  assign pc_in[4] = PC_4;
  assign pc_in[5] = PC_5;
  assign pc_in[6] = PC_6;
  assign pc_in[7] = PC_7;

  // Fetched words and their addresses, presented slot by slot.
  assign InstrF0  = instr_q[0];
  assign InstrF1  = instr_q[1];
  assign InstrF2  = instr_q[2];
  assign InstrF3  = instr_q[3];
  assign InstrF4  = instr_q[4];
  assign InstrF5  = instr_q[5];
  assign InstrF6  = instr_q[6];
  assign InstrF7  = instr_q[7];
  assign next_PC0 = npc_q[0];
  assign next_PC1 = npc_q[1];
  assign next_PC2 = npc_q[2];
  assign next_PC3 = npc_q[3];
  assign next_PC4 = npc_q[4];
  assign next_PC5 = npc_q[5];
  assign next_PC6 = npc_q[6];
  assign next_PC7 = npc_q[7];

  assign fetch_addr = base_q + {27'd0, k_q, 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs; redirect overrides every transition.
  always_comb begin
    state_d   = state_q;
    imem_req  = req_q;
    imem_addr = fetch_addr;
    new_PC    = 1'b0;
    grp_valid = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (req_q && imem_ack && (k_q == 3'd7)) begin
          state_d = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        new_PC = 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_d = S_DELIVER;
      end
      S_DELIVER: begin
        grp_valid = 1'b1;
        if (grp_ready) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (redirect_valid) begin
      state_d = S_FETCH;
    end
  end

  // First slot whose corrected PC departs from the sequential address decides mask and next base.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pc_in[i] != npc_q[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
    mask_d  = 8'hFF;
    nbase_d = pc_in[7] + 32'd4;
    if (hit) begin
      mask_d  = 8'hFF >> (3'd7 - hit_idx);
      nbase_d = pc_in[hit_idx];
    end
  end

  // Fetch datapath, settle counter and group registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= RESET_PC;
      k_q         <= 3'd0;
      req_q       <= 1'b0;
      settle_q    <= 4'd0;
      grp_mask_q  <= 8'd0;
      grp_instr_q <= '0;
      grp_pc_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        instr_q[i] <= 32'd0;
        npc_q[i]   <= 32'd0;
      end
    end else if (redirect_valid) begin
      // Any group in flight is dropped; the request line idles for one cycle.
      base_q     <= redirect_pc;
      k_q        <= 3'd0;
      req_q      <= 1'b0;
      settle_q   <= 4'd0;
      grp_mask_q <= 8'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q[k_q] <= imem_rdata;
            npc_q[k_q]   <= fetch_addr;
            k_q          <= k_q + 3'd1;
            if (k_q == 3'd7) begin
              req_q <= 1'b0;
            end
          end
        end
        S_PUBLISH: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= 4'd0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          grp_mask_q <= mask_d;
          base_q     <= nbase_d;
          for (int i = 0; i < 8; i++) begin
            grp_instr_q[32*i +: 32] <= instr_q[i];
            grp_pc_q[32*i +: 32]    <= npc_q[i];
          end
        end
        S_DELIVER: begin
          // Next group fetch starts right after the accepting edge.
          if (grp_ready) begin
            k_q   <= 3'd0;
            req_q <= 1'b1;
          end
        end
        default: begin
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign grp_mask  = grp_mask_q;
  assign grp_instr = grp_instr_q;
  assign grp_pc    = grp_pc_q;

endmodule

// File: tb/tb_fetch_group_seq.sv
// Self-checking bench for fetch_group_seq with a memory responder, a correction-unit model and a group reference model.
// Latency: measured from the first imem_req cycle to grp_valid.
// Backpressure: grp_ready and imem_ack wait states are driven by the bench.
module tb_fetch_group_seq;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr_o [8];
  logic [31:0]   npc_o   [8];
  logic          new_PC;
  logic [31:0]   pc_ret  [8];
  logic          grp_valid;
  logic          grp_ready = 1'b0;
  logic [7:0]    grp_mask;
  logic [255:0]  grp_instr;
  logic [255:0]  grp_pc;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory image: overrides, else nops (mode 0) or hashed pseudo-random words (mode 1).
  logic [31:0] mem_ovr [logic [31:0]];
  int          mem_mode   = 0;
  int          wait_fixed = 0;
  bit          wait_rand  = 1'b0;
  logic [31:0] ack_log [$];
  int          unstable   = 0;

  fetch_group_seq #(.RESET_PC(32'h0000_0000), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrF0(instr_o[0]), .InstrF1(instr_o[1]), .InstrF2(instr_o[2]), .InstrF3(instr_o[3]),
    .InstrF4(instr_o[4]), .InstrF5(instr_o[5]), .InstrF6(instr_o[6]), .InstrF7(instr_o[7]),
    .next_PC0(npc_o[0]), .next_PC1(npc_o[1]), .next_PC2(npc_o[2]), .next_PC3(npc_o[3]),
    .next_PC4(npc_o[4]), .next_PC5(npc_o[5]), .next_PC6(npc_o[6]), .next_PC7(npc_o[7]),
    .new_PC(new_PC),
    .PC_0(pc_ret[0]), .PC_1(pc_ret[1]), .PC_2(pc_ret[2]), .PC_3(pc_ret[3]),
    .PC_4(pc_ret[4]), .PC_5(pc_ret[5]), .PC_6(pc_ret[6]), .PC_7(pc_ret[7]),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_mask(grp_mask),
    .grp_instr(grp_instr), .grp_pc(grp_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    if (mem_mode == 0) return 32'h0000_0013;
    h = (a ^ 32'hA5A5_1234) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    if (h[4:2] == 3'd0) return {16'h1000, h[31:16]};
    if (h[31:16] == 16'h1000) h[31] = 1'b1;
    return h;
  endfunction

  // Unconditional branch: target = pc + 4 + sign-extended word offset.
  function automatic logic [31:0] corr_pc(input logic [31:0] w, input logic [31:0] pc);
    if (w[31:16] == 16'h1000) return pc + 32'd4 + {{14{w[15]}}, w[15:0], 2'b00};
    return pc;
  endfunction

  // Correction unit model.
  always_comb begin
    for (int i = 0; i < 8; i++) pc_ret[i] = corr_pc(instr_o[i], npc_o[i]);
  end

  // Expected group for a given base address.
  function automatic void model_group(input logic [31:0] base, output logic [7:0] mask,
                                      output logic [255:0] ins, output logic [255:0] pcs,
                                      output logic [31:0] nb);
    logic [31:0] a, w;
    int f;
    f = -1;
    nb = 32'd0;
    ins = '0;
    pcs = '0;
    for (int i = 0; i < 8; i++) begin
      a = base + 32'(4 * i);
      w = mem_word(a);
      ins[32*i +: 32] = w;
      pcs[32*i +: 32] = a;
      if (f < 0 && corr_pc(w, a) != a) begin
        f = i;
        nb = corr_pc(w, a);
      end
    end
    if (f < 0) begin
      mask = 8'hFF;
      nb = base + 32'd32;
    end else begin
      mask = 8'hFF >> (7 - f);
    end
  endfunction

  // Memory responder with configurable wait states; flags address changes during a wait.
  initial begin
    bit prev_req, prev_ack, cur_ack;
    logic [31:0] prev_addr;
    int wcnt, need;
    prev_req = 0; prev_ack = 0; prev_addr = 0; wcnt = 0; need = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      cur_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (prev_req && !prev_ack && imem_addr != prev_addr) unstable++;
        if (prev_req && !prev_ack && imem_addr == prev_addr) begin
          wcnt++;
        end else begin
          wcnt = 0;
          need = wait_rand ? int'($urandom_range(0, 2)) : wait_fixed;
        end
        if (wcnt >= need) cur_ack = 1'b1;
      end
      imem_ack = cur_ack;
      imem_rdata = cur_ack ? mem_word(imem_addr) : $urandom;
      if (cur_ack) ack_log.push_back(imem_addr);
      prev_req = (imem_req === 1'b1);
      prev_ack = cur_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic wait_grp(input int budget, output int cyc, output int npc);
    cyc = -1;
    npc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (new_PC) npc++;
      if (grp_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic accept();
    grp_ready = 1'b1;
    @(posedge clk); #1;
    grp_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    ack_log.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_chk++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_chk++; if (new_PC !== 1'b0 || grp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: new_PC %b grp_valid %b want 0 0", new_PC, grp_valid); end
    n_chk++; if (grp_mask !== 8'd0) begin n_fail++; $display("FAIL rst_mask: got %h want 00", grp_mask); end
    n_chk++; if (instr_o[0] !== 32'd0 || npc_o[7] !== 32'd0 || grp_instr !== '0 || grp_pc !== '0) begin
      n_fail++; $display("FAIL rst_data: InstrF0 %h next_PC7 %h grp nonzero, want all 0", instr_o[0], npc_o[7]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", imem_req); end
  endtask

  task automatic test_nop_group();
    int cyc, npc;
    wait_grp(40, cyc, npc);
    n_chk++; if (cyc !== 10) begin n_fail++; $display("FAIL nop_latency: got %0d want 10", cyc); end
    n_chk++; if (npc !== 1) begin n_fail++; $display("FAIL nop_newpc_cycles: got %0d want 1", npc); end
    n_chk++; if (ack_log.size() !== 8) begin n_fail++; $display("FAIL nop_acks: got %0d want 8", ack_log.size()); end
    for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
      n_chk++; if (ack_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL nop_addr%0d: got %h want %h", i, ack_log[i], 4 * i); end
    end
    n_chk++; if (grp_mask !== 8'hFF) begin n_fail++; $display("FAIL nop_mask: got %h want ff", grp_mask); end
    n_chk++; if (grp_pc[31:0] !== 32'h0) begin n_fail++; $display("FAIL nop_pc0: got %h want 0", grp_pc[31:0]); end
    n_chk++; if (grp_instr[255:224] !== 32'h13) begin n_fail++; $display("FAIL nop_instr7: got %h want 13", grp_instr[255:224]); end
    accept();
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL nop_next: got %h want 20", imem_addr); end
  endtask

  task automatic test_branch_slot3();
    int cyc, npc;
    mem_mode = 0;
    mem_ovr[32'h0C] = 32'h1000_0004;
    do_redirect(32'h0);
    wait_grp(40, cyc, npc);
    n_chk++; if (cyc < 0) begin n_fail++; $display("FAIL br3_timeout: no grp_valid"); end
    n_chk++; if (grp_mask !== 8'h0F) begin n_fail++; $display("FAIL br3_mask: got %h want 0f", grp_mask); end
    n_chk++; if (grp_instr[127:96] !== 32'h1000_0004) begin n_fail++; $display("FAIL br3_instr: got %h want 10000004", grp_instr[127:96]); end
    accept();
    n_chk++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br3_next: got %h want 20", imem_addr); end
    mem_ovr.delete();
  endtask

  task automatic test_branch_self();
    int cyc, npc;
    mem_ovr[32'h11C] = 32'h1000_FFFF;
    do_redirect(32'h100);
    wait_grp(40, cyc, npc);
    n_chk++; if (grp_mask !== 8'hFF) begin n_fail++; $display("FAIL br7_mask: got %h want ff", grp_mask); end
    n_chk++; if (grp_pc[255:224] !== 32'h11C) begin n_fail++; $display("FAIL br7_pc7: got %h want 11c", grp_pc[255:224]); end
    accept();
    n_chk++; if (imem_addr !== 32'h120) begin n_fail++; $display("FAIL br7_next: got %h want 120", imem_addr); end
    mem_ovr.delete();
  endtask

  task automatic test_wait_states();
    int cyc, npc;
    logic [7:0] m; logic [255:0] ins, pcs; logic [31:0] nb;
    mem_mode = 1;
    wait_fixed = 3;
    unstable = 0;
    do_redirect(32'h200);
    model_group(32'h200, m, ins, pcs, nb);
    wait_grp(200, cyc, npc);
    n_chk++; if (cyc < 0) begin n_fail++; $display("FAIL ws_timeout: no grp_valid"); end
    n_chk++; if (unstable !== 0) begin n_fail++; $display("FAIL ws_addr_stable: %0d changes want 0", unstable); end
    n_chk++; if (ack_log.size() !== 8) begin n_fail++; $display("FAIL ws_acks: got %0d want 8", ack_log.size()); end
    for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
      n_chk++; if (ack_log[i] !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL ws_addr%0d: got %h want %h", i, ack_log[i], 32'h200 + 4 * i); end
    end
    n_chk++; if (grp_instr !== ins) begin n_fail++; $display("FAIL ws_instr: got %h want %h", grp_instr, ins); end
    n_chk++; if (grp_mask !== m) begin n_fail++; $display("FAIL ws_mask: got %h want %h", grp_mask, m); end
    accept();
    wait_fixed = 0;
  endtask

  task automatic test_redirect_mid();
    int cyc, npc;
    bit seen;
    logic [7:0] m; logic [255:0] ins, pcs; logic [31:0] nb;
    do_redirect(32'h300);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (ack_log.size() == 5) begin seen = 1; break; end
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rd_reach_k5: acks %0d want 5", ack_log.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_gap: got %b want 0", imem_req); end
    n_chk++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL rd_addr: got %h want 400", imem_addr); end
    n_chk++; if (grp_valid !== 1'b0 || new_PC !== 1'b0) begin n_fail++; $display("FAIL rd_idle: grp_valid %b new_PC %b want 0 0", grp_valid, new_PC); end
    @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL rd_restart: req %b addr %h want 1 400", imem_req, imem_addr); end
    model_group(32'h400, m, ins, pcs, nb);
    wait_grp(60, cyc, npc);
    n_chk++; if (grp_pc !== pcs) begin n_fail++; $display("FAIL rd_grp_pc: got %h want %h", grp_pc, pcs); end
    n_chk++; if (grp_instr !== ins) begin n_fail++; $display("FAIL rd_grp_instr: got %h want %h", grp_instr, ins); end
    accept();
  endtask

  task automatic test_backpressure();
    int cyc, npc, changed, reqs, drops;
    logic [7:0] sm; logic [255:0] si, sp;
    logic [7:0] m; logic [255:0] ins, pcs; logic [31:0] nb;
    do_redirect(32'h500);
    model_group(32'h500, m, ins, pcs, nb);
    wait_grp(60, cyc, npc);
    sm = grp_mask; si = grp_instr; sp = grp_pc;
    changed = 0; reqs = 0; drops = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (grp_mask !== sm || grp_instr !== si || grp_pc !== sp) changed++;
      if (imem_req !== 1'b0) reqs++;
      if (grp_valid !== 1'b1) drops++;
    end
    n_chk++; if (changed !== 0) begin n_fail++; $display("FAIL bp_stable: %0d changed cycles want 0", changed); end
    n_chk++; if (reqs !== 0) begin n_fail++; $display("FAIL bp_no_req: %0d req cycles want 0", reqs); end
    n_chk++; if (drops !== 0) begin n_fail++; $display("FAIL bp_valid_held: %0d low cycles want 0", drops); end
    n_chk++; if (sp !== pcs) begin n_fail++; $display("FAIL bp_pc: got %h want %h", sp, pcs); end
    accept();
    n_chk++; if (imem_addr !== nb) begin n_fail++; $display("FAIL bp_next: got %h want %h", imem_addr, nb); end
  endtask

  task automatic test_wrap();
    int cyc, npc;
    mem_mode = 0;
    do_redirect(32'hFFFF_FFE0);
    wait_grp(40, cyc, npc);
    n_chk++; if (grp_mask !== 8'hFF) begin n_fail++; $display("FAIL wrap_mask: got %h want ff", grp_mask); end
    n_chk++; if (grp_pc[255:224] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc7: got %h want fffffffc", grp_pc[255:224]); end
    accept();
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
  endtask

  task automatic test_random();
    int cyc, npc;
    logic [31:0] base;
    logic [7:0] m; logic [255:0] ins, pcs; logic [31:0] nb;
    mem_mode = 1;
    wait_rand = 1'b1;
    base = $urandom & 32'hFFFF_FFFC;
    do_redirect(base);
    for (int g = 0; g < 15; g++) begin
      model_group(base, m, ins, pcs, nb);
      wait_grp(200, cyc, npc);
      n_chk++; if (cyc < 0) begin n_fail++; $display("FAIL rnd_timeout g%0d", g); break; end
      n_chk++; if (grp_mask !== m) begin n_fail++; $display("FAIL rnd_mask g%0d: got %h want %h", g, grp_mask, m); end
      n_chk++; if (grp_instr !== ins) begin n_fail++; $display("FAIL rnd_instr g%0d: got %h want %h", g, grp_instr, ins); end
      n_chk++; if (grp_pc !== pcs) begin n_fail++; $display("FAIL rnd_pc g%0d: got %h want %h", g, grp_pc, pcs); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      accept();
      n_chk++; if (imem_addr !== nb) begin n_fail++; $display("FAIL rnd_next g%0d: got %h want %h", g, imem_addr, nb); end
      base = nb;
    end
    wait_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nop_group();
    test_branch_slot3();
    test_branch_self();
    test_wait_states();
    test_redirect_mid();
    test_backpressure();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
